// File: rtl/nx1_pkg.sv
// Shared constants and types for the X1 I/O mode-latch block: PIA register
// indices, DAM bit position, wait counter width and wait FSM encoding.
package nx1_pkg;

  localparam logic [1:0] PIA_PORTC   = 2'd2;
  localparam logic [1:0] PIA_BSR     = 2'd3;
  localparam int         DAM_BIT     = 5;
  localparam logic [2:0] DAM_BSR_SEL = 3'b101;
  localparam int         CNT_W       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

  // Returns {set, clr} for a PIA write; DAM tracks port C bit 5 inverted.
  function automatic logic [1:0] pia_dam_decode(input logic [1:0] a, input logic [7:0] d);
    logic [1:0] r;
    r = 2'b00;
    if (a == PIA_PORTC) begin
      r = d[DAM_BIT] ? 2'b01 : 2'b10;
    end else if (a == PIA_BSR && !d[7] && d[3:1] == DAM_BSR_SEL) begin
      r = d[0] ? 2'b01 : 2'b10;
    end
    return r;
  endfunction

endpackage

// File: rtl/nx1_io_edge.sv
// Two-register sampler for a bus condition, producing the first-stage level
// and a one-clock pulse on its rising edge.
module nx1_io_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic s1_o,
  output logic pulse_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= lvl_i;
      s2_q <= s1_q;
    end
  end

  assign s1_o    = s1_q;
  assign pulse_o = s1_q & ~s2_q;

endmodule

// File: rtl/nx1_iomode.sv
// X1 mode latches (IPL select, DAM) and I/O cycle strobes with optional VRAM
// wait sequencer, built only when NX1_IOWAIT_EN is defined.
//   state   | meaning
//   ST_IDLE | no wait requested, O_WAIT_n high
//   ST_WAIT | counting VRAM wait states, O_WAIT_n low
module nx1_iomode
  import nx1_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_IORQ_n,
  input  logic       I_RD_n,
  input  logic       I_WR_n,
  input  logic [7:0] I_D,
  input  logic [1:0] I_A,
  input  logic       I_IPL_SET_CS,
  input  logic       I_IPL_RES_CS,
  input  logic       I_PIA_CS,
  input  logic       I_DAM_CLR,
  input  logic       I_VRAM_CS,
  output logic       O_IPL_SEL,
  output logic       O_DAM,
  output logic       O_IOWR_STB,
  output logic       O_IORD_STB,
  output logic       O_WAIT_n
);

  logic io_wr, io_rd;
  logic wr_s1, rd_s1, clr_s1;
  logic wr_stb, rd_stb, clr_stb;
  logic ipl_q, ipl_d;
  logic dam_q, dam_d;
  logic dam_set, dam_clr;

  assign io_wr = ~I_IORQ_n & ~I_WR_n;
  assign io_rd = ~I_IORQ_n & ~I_RD_n;

  nx1_io_edge u_wr (
    .clk_i  (I_CLK),
    .rst_i  (I_RESET),
    .lvl_i  (io_wr),
    .s1_o   (wr_s1),
    .pulse_o(wr_stb)
  );

  nx1_io_edge u_rd (
    .clk_i  (I_CLK),
    .rst_i  (I_RESET),
    .lvl_i  (io_rd),
    .s1_o   (rd_s1),
    .pulse_o(rd_stb)
  );

  nx1_io_edge u_clr (
    .clk_i  (I_CLK),
    .rst_i  (I_RESET),
    .lvl_i  (I_DAM_CLR),
    .s1_o   (clr_s1),
    .pulse_o(clr_stb)
  );

  always_comb begin
    ipl_d = ipl_q;
    if (wr_stb & I_IPL_RES_CS) begin
      ipl_d = 1'b0;
    end else if (wr_stb & I_IPL_SET_CS) begin
      ipl_d = 1'b1;
    end
  end

  assign {dam_set, dam_clr} = pia_dam_decode(I_A, I_D) & {2{wr_stb & I_PIA_CS}};

  always_comb begin
    dam_d = dam_q;
    if (dam_clr | clr_stb) begin
      dam_d = 1'b0;
    end else if (dam_set) begin
      dam_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      ipl_q <= 1'b1;
      dam_q <= 1'b0;
    end else begin
      ipl_q <= ipl_d;
      dam_q <= dam_d;
    end
  end

  assign O_IPL_SEL  = ipl_q;
  assign O_DAM      = dam_q;
  assign O_IOWR_STB = wr_stb;
  assign O_IORD_STB = rd_stb;

`ifdef NX1_IOWAIT_EN
  wait_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_wr_q, act_wr_d;
  logic             act_s1;
  logic             unused_ok;

  // Abort tracks whichever cycle type opened the wait.
  assign act_s1 = act_wr_q ? wr_s1 : rd_s1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_wr_d = act_wr_q;
    case (state_q)
      ST_IDLE: begin
        if ((wr_stb | rd_stb) & I_VRAM_CS & (WAIT_CYC != 0)) begin
          state_d  = ST_WAIT;
          cnt_d    = CNT_W'(WAIT_CYC - 1);
          act_wr_d = wr_stb;
        end
      end
      ST_WAIT: begin
        if (!act_s1 || cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      act_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      act_wr_q <= act_wr_d;
    end
  end

  assign O_WAIT_n  = (state_q != ST_WAIT);
  assign unused_ok = clr_s1;
`else
  logic unused_ok;

  assign O_WAIT_n  = 1'b1;
  assign unused_ok = ^{clr_s1, wr_s1, rd_s1, I_VRAM_CS, CNT_W'(WAIT_CYC)};
`endif

endmodule

// File: tb/tb_nx1_iomode.sv
// Directed bench for nx1_iomode: per-cycle expected output vectors are queued
// as stimulus is applied and compared after each clock edge.
module tb_nx1_iomode;

`ifdef NX1_IOWAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] d;
  logic [1:0] a;
  logic       ipl_set_cs, ipl_res_cs, pia_cs, dam_clr, vram_cs;
  logic       ipl_sel, dam, iowr_stb, iord_stb, wait_n;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_t;

  sb_t q[$];
  int  errors = 0;
  int  checks = 0;

  nx1_iomode #(.WAIT_CYC(3)) dut (
    .I_CLK       (clk),
    .I_RESET     (rst),
    .I_IORQ_n    (iorq_n),
    .I_RD_n      (rd_n),
    .I_WR_n      (wr_n),
    .I_D         (d),
    .I_A         (a),
    .I_IPL_SET_CS(ipl_set_cs),
    .I_IPL_RES_CS(ipl_res_cs),
    .I_PIA_CS    (pia_cs),
    .I_DAM_CLR   (dam_clr),
    .I_VRAM_CS   (vram_cs),
    .O_IPL_SEL   (ipl_sel),
    .O_DAM       (dam),
    .O_IOWR_STB  (iowr_stb),
    .O_IORD_STB  (iord_stb),
    .O_WAIT_n    (wait_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ipl, dam, wr_stb, rd_stb, wait_n}; wait low only exists when the FSM is built
  function automatic logic [4:0] v(input bit ipl, input bit dm, input bit ws, input bit rs,
                                   input bit wlow);
    return {ipl, dm, ws, rs, ~(WEN & wlow)};
  endfunction

  task automatic step(input string tag, input logic [4:0] e);
    sb_t        it;
    logic [4:0] obs;
    q.push_back('{tag, e});
    @(posedge clk);
    #1;
    it  = q.pop_front();
    obs = {ipl_sel, dam, iowr_stb, iord_stb, wait_n};
    checks++;
    assert (obs === it.exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (ipl,dam,wr,rd,wait_n) t=%0t", it.tag, obs, it.exp, $time);
    end
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    ipl_set_cs = 1'b0; ipl_res_cs = 1'b0; pia_cs = 1'b0; dam_clr = 1'b0; vram_cs = 1'b0;
    a = 2'd0; d = 8'h00;
  endtask

  task automatic bus_wr(input logic [1:0] aa, input logic [7:0] dd);
    iorq_n = 1'b0; wr_n = 1'b0; a = aa; d = dd;
  endtask

  task automatic bus_rd();
    iorq_n = 1'b0; rd_n = 1'b0; dam_clr = 1'b1;
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    step("reset0", v(1, 0, 0, 0, 0));
    step("reset1", v(1, 0, 0, 0, 0));
    rst = 1'b0;
    step("idle0", v(1, 0, 0, 0, 0));
    step("idle1", v(1, 0, 0, 0, 0));

    // IPL reset write held 4 clocks
    bus_wr(2'd0, 8'h00); ipl_res_cs = 1'b1;
    step("iplres_stb", v(1, 0, 1, 0, 0));
    step("iplres_k1", v(0, 0, 0, 0, 0));
    step("iplres_k2", v(0, 0, 0, 0, 0));
    step("iplres_k3", v(0, 0, 0, 0, 0));
    bus_idle();
    step("iplres_rel", v(0, 0, 0, 0, 0));
    step("iplres_idle", v(0, 0, 0, 0, 0));

    bus_wr(2'd0, 8'h00); ipl_set_cs = 1'b1;
    step("iplset_stb", v(0, 0, 1, 0, 0));
    step("iplset_k1", v(1, 0, 0, 0, 0));
    bus_idle();
    step("iplset_rel", v(1, 0, 0, 0, 0));

    // BSR 0x0A sets DAM, I/O read clears it
    bus_wr(2'd3, 8'h0A); pia_cs = 1'b1;
    step("bsr_set_stb", v(1, 0, 1, 0, 0));
    step("bsr_set_k1", v(1, 1, 0, 0, 0));
    bus_idle();
    step("bsr_set_rel", v(1, 1, 0, 0, 0));
    bus_rd();
    step("rd_clr_stb", v(1, 1, 0, 1, 0));
    step("rd_clr_k1", v(1, 0, 0, 0, 0));
    bus_idle();
    step("rd_clr_rel", v(1, 0, 0, 0, 0));

    bus_wr(2'd2, 8'hDF); pia_cs = 1'b1;
    step("pc_set_stb", v(1, 0, 1, 0, 0));
    step("pc_set_k1", v(1, 1, 0, 0, 0));
    bus_idle();
    step("pc_set_rel", v(1, 1, 0, 0, 0));

    // BSR to another bit must leave DAM alone
    bus_wr(2'd3, 8'h0D); pia_cs = 1'b1;
    step("bsr_other_stb", v(1, 1, 1, 0, 0));
    step("bsr_other_k1", v(1, 1, 0, 0, 0));
    bus_idle();
    step("bsr_other_rel", v(1, 1, 0, 0, 0));

    bus_wr(2'd2, 8'h20); pia_cs = 1'b1;
    step("pc_clr_stb", v(1, 1, 1, 0, 0));
    step("pc_clr_k1", v(1, 0, 0, 0, 0));
    bus_idle();
    step("pc_clr_rel", v(1, 0, 0, 0, 0));

    bus_wr(2'd3, 8'h0A); pia_cs = 1'b1;
    step("bsr_set2_stb", v(1, 0, 1, 0, 0));
    step("bsr_set2_k1", v(1, 1, 0, 0, 0));
    bus_idle();
    step("bsr_set2_rel", v(1, 1, 0, 0, 0));
    bus_wr(2'd3, 8'h0B); pia_cs = 1'b1;
    step("bsr_clr_stb", v(1, 1, 1, 0, 0));
    step("bsr_clr_k1", v(1, 0, 0, 0, 0));
    bus_idle();
    step("bsr_clr_rel", v(1, 0, 0, 0, 0));

    // simultaneous DAM set and DAM_CLR edge: clear wins
    bus_wr(2'd2, 8'hDF); pia_cs = 1'b1; dam_clr = 1'b1;
    step("dam_prio_stb", v(1, 0, 1, 0, 0));
    step("dam_prio_k1", v(1, 0, 0, 0, 0));
    bus_idle();
    step("dam_prio_rel", v(1, 0, 0, 0, 0));

    // both IPL selects: RES wins
    bus_wr(2'd0, 8'h00); ipl_set_cs = 1'b1; ipl_res_cs = 1'b1;
    step("ipl_prio_stb", v(1, 0, 1, 0, 0));
    step("ipl_prio_k1", v(0, 0, 0, 0, 0));
    bus_idle();
    step("ipl_prio_rel", v(0, 0, 0, 0, 0));
    bus_wr(2'd0, 8'h00); ipl_set_cs = 1'b1;
    step("iplset2_stb", v(0, 0, 1, 0, 0));
    step("iplset2_k1", v(1, 0, 0, 0, 0));
    bus_idle();
    step("iplset2_rel", v(1, 0, 0, 0, 0));

    // VRAM read with full 3-clock wait
    bus_rd(); vram_cs = 1'b1;
    step("wait_stb", v(1, 0, 0, 1, 0));
    step("wait_w1", v(1, 0, 0, 0, 1));
    step("wait_w2", v(1, 0, 0, 0, 1));
    step("wait_w3", v(1, 0, 0, 0, 1));
    step("wait_done", v(1, 0, 0, 0, 0));
    step("wait_hold", v(1, 0, 0, 0, 0));
    bus_idle();
    step("wait_rel", v(1, 0, 0, 0, 0));

    // VRAM read released after one wait clock aborts the wait
    bus_rd(); vram_cs = 1'b1;
    step("abort_stb", v(1, 0, 0, 1, 0));
    step("abort_w1", v(1, 0, 0, 0, 1));
    bus_idle();
    step("abort_s1drop", v(1, 0, 0, 0, 1));
    step("abort_idle", v(1, 0, 0, 0, 0));
    step("abort_idle2", v(1, 0, 0, 0, 0));

    // VRAM write clearing IPL, reset mid-wait, strobe held across reset
    bus_wr(2'd0, 8'h00); ipl_res_cs = 1'b1; vram_cs = 1'b1;
    step("rstw_stb", v(1, 0, 1, 0, 0));
    step("rstw_w1", v(0, 0, 0, 0, 1));
    rst = 1'b1;
    step("rstw_reset", v(1, 0, 0, 0, 0));
    rst = 1'b0;
    step("rstw_restb", v(1, 0, 1, 0, 0));
    step("rstw_rew1", v(0, 0, 0, 0, 1));
    bus_idle();
    step("rstw_s1drop", v(0, 0, 0, 0, 1));
    step("rstw_idle", v(0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nx1_iomode.md
# nx1_iomode

Mode-latch and I/O-cycle sequencer directly downstream of the X1 address decoder. It consumes the decoder's chip selects (`IPL_SET`/`IPL_RES`, PIA, DAM clear, VRAM/GRAM) together with the Z80 bus strobes. It produces the registered mode bits `O_IPL_SEL` and `O_DAM`, which feed back into the decoder, plus one-cycle I/O read/write strobes and an optional VRAM wait request.

## Interface
Parameters:
- `WAIT_CYC`, default 2: wait-state length in clocks for VRAM/GRAM I/O. Range 0..15; 0 means no wait.

Ports:
- `I_CLK` in 1: system clock. Single clock domain.
- `I_RESET` in 1: synchronous, active-high reset.
- `I_IORQ_n`, `I_RD_n`, `I_WR_n` in 1 each: Z80 bus strobes, active low.
- `I_D` in 8: CPU data bus, write data.
- `I_A` in 2: `A[1:0]`, PIA register select.
- `I_IPL_SET_CS`, `I_IPL_RES_CS`, `I_PIA_CS` in 1 each: decoded selects (1Dxx, 1Exx, 1Axx).
- `I_DAM_CLR` in 1: decoder DAM-clear level (IORQ & RD).
- `I_VRAM_CS` in 1: OR of `ATTR`/`TEXT`/`KANJI`/`GRB`/`GRR`/`GRG` selects.
- `O_IPL_SEL` out 1: IPL ROM mapped at 0000-7FFF on reads.
- `O_DAM` out 1: double-access (simultaneous GRAM write) mode.
- `O_IOWR_STB`, `O_IORD_STB` out 1 each: one-clock pulse at the start of an I/O write or read.
- `O_WAIT_n` out 1: Z80 wait request, active low.

## Operation
- Cycle detect: `io_wr` = ~IORQ_n & ~WR_n and `io_rd` = ~IORQ_n & ~RD_n. Each is registered through `s1` then `s2`; start pulse = `s1` & ~`s2`.
- IPL latch:
  - Reset value 1.
  - On `O_IOWR_STB` & `I_IPL_SET_CS`, set to 1.
  - On `O_IOWR_STB` & `I_IPL_RES_CS`, clear to 0.
  - If both selects are true, RES wins.
- DAM latch: reset value 0.
  - Set on `O_IOWR_STB` & `I_PIA_CS` in either of two cases:
    - direct port C write: `A`=2 and `D[5]`=0.
    - bit set/reset write: `A`=3, `D[7]`=0, `D[3:1]`=3'b101, `D[0]`=0.
  - Port C write with `D[5]`=1, or BSR with `D[0]`=1, clears DAM.
  - A rising edge of `I_DAM_CLR` (registered like the strobes) clears DAM.
  - Clear has priority when both occur in the same clock.
- Write data and selects are sampled in the same clock as the start pulse.
- Wait FSM, states IDLE and WAIT. 4-bit down-counter `cnt`.
  - IDLE → WAIT on a start pulse (rd or wr) with `I_VRAM_CS`=1 and `WAIT_CYC`≠0; load `cnt`=`WAIT_CYC`-1.
  - In WAIT, decrement each clock; WAIT → IDLE when `cnt`=0.
  - Abort to IDLE immediately if `s1` of the active cycle drops (IORQ released).
  - `O_WAIT_n` = 0 exactly while in WAIT.

## Timing
- Bus condition first sampled true at edge k, false at k-1: the strobe is high from edge k to edge k+1.
- `O_IPL_SEL` and `O_DAM` update at edge k+1, giving 1-cycle latency from strobe to mode bit.
- `O_WAIT_n` falls at edge k+1 and stays low for `WAIT_CYC` clocks.
- Reset values: `O_IPL_SEL`=1, `O_DAM`=0, `O_IOWR_STB`=0, `O_IORD_STB`=0, `O_WAIT_n`=1.
- `s1`/`s2` reset to 0, so a strobe held active across reset produces a start pulse one clock after reset release.
- Reset mid-wait returns the FSM to IDLE immediately.
- A held strobe produces exactly one pulse per assertion. A new pulse requires a deassertion of at least 1 clock.

## Configuration
- `NX1_IOWAIT_EN` defined: wait FSM and counter are built; `WAIT_CYC` is honoured.
- Not defined: FSM and counter are omitted, `O_WAIT_n` is tied to 1, and `WAIT_CYC` is ignored. All other behaviour is identical.

## Structure
- Shared package `nx1_pkg`:
  - PIA port C and BSR register indices (2, 3).
  - DAM bit index (5).
  - Wait counter width (4).
  - FSM state encoding (IDLE=0, WAIT=1).
- Sub-module `nx1_io_edge`: 2-register sampler plus rising-edge pulse. Instantiated three times: wr, rd, DAM clear.

## Test plan
- Reset, then idle → `O_IPL_SEL`=1, `O_DAM`=0, `O_WAIT_n`=1, no strobes.
- I/O write with `I_IPL_RES_CS`=1, held 4 clocks → exactly one `O_IOWR_STB`; `O_IPL_SEL`=0 one clock later. A subsequent `IPL_SET` write → 1.
- PIA write `A`=3, `D`=8'h0A → `O_DAM`=1. Then any I/O read → `O_DAM`=0 one clock after the `DAM_CLR` edge.
- PIA write `A`=2, `D`=8'hDF → `O_DAM`=1. PIA write `A`=2, `D`=8'h20 → `O_DAM`=0.
- `WAIT_CYC`=3, I/O read with `I_VRAM_CS`=1 → `O_WAIT_n` low for exactly 3 clocks. Release IORQ after 1 wait clock → `O_WAIT_n`=1 the next clock.
- `I_RESET` asserted during WAIT with `O_IPL_SEL`=0 → next clock `O_WAIT_n`=1, `O_IPL_SEL`=1.
